// File: rtl/cache_control_prefetch_pkg.sv
// Shared encodings for the L1 cache controller. These are the datapath's address-mux selects
// (request address or one of the two writeback addresses).
package cache_control_prefetch_pkg;

  localparam logic [1:0] ADRMUX_REQ  = 2'd0;
  localparam logic [1:0] ADRMUX_WAY0 = 2'd1;
  localparam logic [1:0] ADRMUX_WAY1 = 2'd2;

endpackage

// File: rtl/cache_control_prefetch.sv
// Two-way L1 control FSM: 1-cycle hits, miss = [writeback] + fill, then one next-line prefetch.
// Mealy outputs; CPU is held off (mem_resp=0) during fills, pmem requests held until pmem_resp.
module cache_control_prefetch
  import cache_control_prefetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic       mem_resp,
  output logic       pmem_read,
  output logic       pmem_write,
  input  logic       pmem_resp,
  input  logic       hit0,
  input  logic       hit1,
  input  logic       valid0_out,
  input  logic       valid1_out,
  input  logic       dirty0_out,
  input  logic       dirty1_out,
  input  logic       LRU_out,
  output logic       wb_sel,
  output logic       data0_writeline,
  output logic       data1_writeline,
  output logic       tag0_write,
  output logic       tag1_write,
  output logic       valid0_write,
  output logic       valid1_write,
  output logic       valid_in,
  output logic       dirty0_write,
  output logic       dirty1_write,
  output logic       dirty_in,
  output logic       updateLRU,
  output logic [1:0] adrmux_sel,
  output logic       adr_in_sel,
  output logic       load_prefetch
);

  typedef enum logic [2:0] {
    S_COMPARE,
    S_WRITEBACK,
    S_FILL,
    S_PF_CHECK,
    S_PF_FILL
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   r_pf_armed;
  logic   w_next_armed;

  logic w_req;
  logic w_hit;
  logic w_hit_way;
  logic w_victim_dirty;

  assign w_req          = mem_read | mem_write;
  assign w_hit          = hit0 | hit1;
  assign w_hit_way      = ~hit0;
  assign w_victim_dirty = LRU_out ? (valid1_out & dirty1_out) : (valid0_out & dirty0_out);

  always_comb begin
    w_next_state    = r_state;
    w_next_armed    = r_pf_armed;
    mem_resp        = 1'b0;
    pmem_read       = 1'b0;
    pmem_write      = 1'b0;
    wb_sel          = 1'b0;
    data0_writeline = 1'b0;
    data1_writeline = 1'b0;
    tag0_write      = 1'b0;
    tag1_write      = 1'b0;
    valid0_write    = 1'b0;
    valid1_write    = 1'b0;
    valid_in        = 1'b0;
    dirty0_write    = 1'b0;
    dirty1_write    = 1'b0;
    dirty_in        = 1'b0;
    updateLRU       = 1'b0;
    adrmux_sel      = ADRMUX_REQ;
    adr_in_sel      = 1'b0;
    load_prefetch   = 1'b0;

    case (r_state)
      S_COMPARE: begin
        if (!w_req) begin
          if (r_pf_armed) w_next_state = S_PF_CHECK;
        end else if (w_hit) begin
          mem_resp  = 1'b1;
          updateLRU = (w_hit_way == LRU_out);
          if (mem_write) begin
            wb_sel   = 1'b1;
            dirty_in = 1'b1;
            if (w_hit_way) begin
              data1_writeline = 1'b1;
              dirty1_write    = 1'b1;
            end else begin
              data0_writeline = 1'b1;
              dirty0_write    = 1'b1;
            end
          end
        end else begin
          load_prefetch = 1'b1;
          w_next_armed  = 1'b1;
          w_next_state  = w_victim_dirty ? S_WRITEBACK : S_FILL;
        end
      end

      S_WRITEBACK: begin
        pmem_write = 1'b1;
        adrmux_sel = LRU_out ? ADRMUX_WAY1 : ADRMUX_WAY0;
        if (pmem_resp) w_next_state = S_FILL;
      end

      S_FILL, S_PF_FILL: begin
        pmem_read  = 1'b1;
        adr_in_sel = (r_state == S_PF_FILL);
        if (pmem_resp) begin
          // Install the returned line clean in the victim way; a prefetched line also becomes MRU.
          valid_in  = 1'b1;
          updateLRU = (r_state == S_PF_FILL);
          if (LRU_out) begin
            data1_writeline = 1'b1;
            tag1_write      = 1'b1;
            valid1_write    = 1'b1;
            dirty1_write    = 1'b1;
          end else begin
            data0_writeline = 1'b1;
            tag0_write      = 1'b1;
            valid0_write    = 1'b1;
            dirty0_write    = 1'b1;
          end
          w_next_state = S_COMPARE;
        end
      end

      S_PF_CHECK: begin
        adr_in_sel   = 1'b1;
        w_next_armed = 1'b0;
        if (w_req || w_hit || w_victim_dirty) w_next_state = S_COMPARE;
        else                                  w_next_state = S_PF_FILL;
      end

      default: w_next_state = S_COMPARE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_COMPARE;
      r_pf_armed <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_pf_armed <= w_next_armed;
    end
  end

endmodule

// File: doc/cache_control_prefetch.md
# cache_control_prefetch

Control FSM for the two-way, eight-set, write-back L1 cache datapath with next-line prefetch. It sits between the CPU-side memory handshake and the physical-memory handshake, and drives every write-enable and mux select of the cache datapath. It serves demand hits in one cycle and services misses with writeback and fill. After each demand miss it issues one opportunistic fill of line `mem_address+1`, staged through the datapath's prefetch address register.

## Interface
Parameters: none.

Clock and reset:
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.

CPU side:
- `mem_read`, `mem_write` in 1 each: CPU request, held until `mem_resp`.
- `mem_resp` out 1: request complete.

Physical memory side:
- `pmem_read`, `pmem_write` out 1 each: line request, held until `pmem_resp`.
- `pmem_resp` in 1: physical memory done.

Datapath status:
- `hit0`, `hit1` in 1 each: tag match plus valid, for the address selected by `adr_in_sel`.
- `valid0_out`, `valid1_out`, `dirty0_out`, `dirty1_out`, `LRU_out` in 1 each: status of the selected set. `LRU_out` is the victim way.

Datapath controls:
- `wb_sel` out 1: 0 = line from pmem, 1 = CPU-merged line.
- `data0_writeline`, `data1_writeline` out 1 each.
- `tag0_write`, `tag1_write` out 1 each.
- `valid0_write`, `valid1_write`, `valid_in` out 1 each.
- `dirty0_write`, `dirty1_write`, `dirty_in` out 1 each.
- `updateLRU` out 1: flips the set's LRU bit.
- `adrmux_sel` out 2: 0 = request address, 1 = way-0 writeback address, 2 = way-1 writeback address.
- `adr_in_sel` out 1: 0 = CPU address, 1 = prefetch register.
- `load_prefetch` out 1: capture `mem_address+1`.

## Operation
States: `COMPARE` (idle/reset), `WRITEBACK`, `FILL`, `PF_CHECK`, `PF_FILL`. There is one flag register, `pf_armed`.

**All outputs are 0 unless listed below.** Outputs are combinational from the state and inputs (Mealy).

**COMPARE** (`adr_in_sel`=0)
- No request:
  - If `pf_armed` is set, go to `PF_CHECK`.
  - Otherwise stay in `COMPARE`.
- Read hit:
  - Assert `mem_resp`.
  - Assert `updateLRU` iff the hit way equals `LRU_out`.
- Write hit:
  - Assert `mem_resp` and `wb_sel`=1.
  - Assert the hit way's `data*_writeline` and `dirty*_write`, with `dirty_in`=1.
  - Assert `updateLRU` under the same rule as a read hit.
- Miss:
  - Assert `load_prefetch` and set `pf_armed`.
  - If the victim way is both valid and dirty, go to `WRITEBACK`; otherwise go to `FILL`.

**WRITEBACK**
- Outputs: `pmem_write`=1, `adrmux_sel`=1+`LRU_out`.
- On `pmem_resp`, go to `FILL`.

**FILL**
- Outputs: `pmem_read`=1, `adrmux_sel`=0.
- On `pmem_resp`, for the victim way:
  - Write data with `wb_sel`=0, and write the tag.
  - Write valid with `valid_in`=1.
  - Write dirty with `dirty_in`=0.
- Then return to `COMPARE`. The request now hits and completes there; no LRU update occurs in `FILL`.

**PF_CHECK** (`adr_in_sel`=1, lasts one cycle; clears `pf_armed`)
- A CPU request is present: abandon the prefetch and go to `COMPARE`.
- `hit0` or `hit1`: go to `COMPARE`.
- Victim is valid and dirty: skip the prefetch (prefetches never write back) and go to `COMPARE`.
- Otherwise go to `PF_FILL`.

**PF_FILL** (`adr_in_sel`=1, `pmem_read`=1, `adrmux_sel`=0)
- Cannot be aborted.
- On `pmem_resp`, write the victim way exactly as in `FILL`, plus `updateLRU`, so the prefetched way becomes MRU. Then go to `COMPARE`.
- A CPU request arriving during `PF_FILL` waits with `mem_resp`=0.

## Timing
- Reset, asynchronous while `reset_n`=0:
  - State goes to `COMPARE` and `pf_armed` clears.
  - `pmem_read`/`pmem_write` drop immediately.
  - Array contents are not touched; clearing valid bits is the datapath's concern.
- Hit latency: `mem_resp` in the same cycle the request is presented in `COMPARE`.
- Clean miss: `FILL` starts at edge +1. After the `pmem_resp` cycle, `mem_resp` comes one cycle later.
- Dirty miss: adds the `WRITEBACK` stay, which is at least 1 cycle.
- Prefetch:
  - `PF_CHECK` follows the first idle `COMPARE` cycle after the missed request's `mem_resp`.
  - Worst-case added latency for a CPU request is the remaining `PF_FILL` duration plus 1 cycle.
- `pmem_read` and `pmem_write` are never asserted together. Each is held until `pmem_resp` and dropped in the following cycle.
- Prefetch address arithmetic is 12-bit modulo: 0xFFF+1 = 0x000. The controller treats this as a normal case.

## Structure
- Package `lc3b_types`: no additions. Keep the state enum local to this module.
- No sub-module: a single state register, the `pf_armed` flop and combinational next-state/output decode.
- Expected size is roughly 150–250 lines.

## Test plan
- **Cold read miss.** Address 0x012, all invalid, pmem latency 3.
  - Expect `FILL` with `pmem_read`, then `adrmux_sel`=0, then way-0 writes, then `mem_resp` one cycle later.
  - Then `PF_CHECK`/`PF_FILL` for 0x013, with `updateLRU` on its `pmem_resp`.
- **Write hit.**
  - Write to 0x012 after the fill: `mem_resp` the same cycle, `wb_sel`=1, `data0_writeline`=1, `dirty_in`=1.
  - No pmem activity.
- **Dirty eviction.** Ways of set 2 hold dirty 0x012 and 0x01A with LRU=0; read 0x022.
  - Expect `WRITEBACK` with `adrmux_sel`=1 (address 0x012), then `FILL` for 0x022.
- **Prefetch suppressed.** Fill 0x0A0 when 0x0A1 is already resident.
  - `PF_CHECK` sees a hit and goes to `COMPARE`; no `pmem_read`.
- **Prefetch contention and wrap-around.**
  - A CPU read raised during `PF_FILL` is held off until `pmem_resp`, then served.
  - A miss at 0xFFF prefetches 0x000.
- **Reset mid-WRITEBACK.** Pulse `reset_n` low for 1 cycle.
  - `pmem_write` drops asynchronously and the state returns to `COMPARE`.
  - No prefetch follows.
